// File: rtl/accum_pkg.sv
// Shared opcodes and width helpers for the accumulator bank.
package accum_pkg;

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_CLEAR = 3'b100;

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic logic signed [63:0] smax(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] smin(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/accum_addsub_sat.sv
// Signed add/subtract with overflow detect and optional clamp to signed max/min.
module accum_addsub_sat
    import accum_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(smax(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(smin(WIDTH));

    logic [WIDTH-1:0] raw;
    logic             sa, sb, sr;

    always_comb begin
        raw = sub_i ? (a_i - b_i) : (a_i + b_i);
        sa  = a_i[WIDTH-1];
        sb  = b_i[WIDTH-1];
        sr  = raw[WIDTH-1];
        ovf_o = sub_i ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        result_o = raw;
        // Overflow direction always follows the sign of the accumulator operand.
        if (ovf_o && sat_i)
            result_o = sa ? MIN_V : MAX_V;
    end

endmodule

// File: rtl/accum_bank.sv
// Bank of CHANNELS signed accumulators sharing one registered result stage
// with valid/ready flow control and per-channel sticky overflow.
module accum_bank
    import accum_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    localparam int CH_W    = ch_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [2:0]          in_op,
    input  logic [WIDTH-1:0]    D,
    input  logic                clr_sticky,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [WIDTH-1:0]    Q,
    output logic                ovf,
    output logic [CHANNELS-1:0] sticky_ovf
);

    logic [WIDTH-1:0]    acc_q [CHANNELS];
    logic [WIDTH-1:0]    acc_d [CHANNELS];
    logic [CHANNELS-1:0] sticky_q, sticky_d;
    logic [WIDTH-1:0]    q_q;
    logic [CH_W-1:0]     out_ch_q;
    logic                ovf_q, out_valid_q;

    logic [WIDTH-1:0]    cur, as_res, new_val;
    logic                ch_ok, as_ovf, new_ovf, accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Decoding by comparison keeps out-of-range channels harmless for any CHANNELS.
    always_comb begin
        cur   = '0;
        ch_ok = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_ch == CH_W'(i)) begin
                cur   = acc_q[i];
                ch_ok = 1'b1;
            end
        end
    end

    accum_addsub_sat #(.WIDTH(WIDTH)) u_addsub (
        .a_i      (cur),
        .b_i      (D),
        .sub_i    (in_op == OP_SUB),
        .sat_i    (SATURATE != 0),
        .result_o (as_res),
        .ovf_o    (as_ovf)
    );

    always_comb begin
        new_val = cur;
        new_ovf = 1'b0;
        case (in_op)
            OP_LOAD:        new_val = D;
            OP_ADD, OP_SUB: begin
                new_val = as_res;
                new_ovf = as_ovf;
            end
            OP_CLEAR:       new_val = '0;
            default:        ;
        endcase
        if (!ch_ok) begin
            new_val = '0;
            new_ovf = 1'b0;
        end
    end

    // Sticky set is applied after the clears so it wins when both coincide.
    always_comb begin
        acc_d    = acc_q;
        sticky_d = clr_sticky ? '0 : sticky_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (accept && (in_ch == CH_W'(i))) begin
                acc_d[i] = new_val;
                if (in_op == OP_CLEAR)
                    sticky_d[i] = 1'b0;
                if (new_ovf)
                    sticky_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++)
                acc_q[i] <= '0;
            sticky_q    <= '0;
            q_q         <= '0;
            out_ch_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                q_q         <= new_val;
                out_ch_q    <= in_ch;
                ovf_q       <= new_ovf;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign Q          = q_q;
    assign ovf        = ovf_q;
    assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_accum_bank.sv
// Directed bench: a wrapping 4-channel bank and a saturating 3-channel bank
// driven in lockstep from the same stimulus.
module tb_accum_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_ch;
    logic [2:0]  in_op;
    logic [15:0] D;
    logic        clr_sticky;
    logic        out_ready;

    logic        in_ready_w, out_valid_w, ovf_w;
    logic [1:0]  out_ch_w;
    logic [15:0] q_w;
    logic [3:0]  sticky_w;

    logic        in_ready_s, out_valid_s, ovf_s;
    logic [1:0]  out_ch_s;
    logic [15:0] q_s;
    logic [2:0]  sticky_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accum_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_ch(in_ch), .in_op(in_op), .D(D), .clr_sticky(clr_sticky),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_ch(out_ch_w),
        .Q(q_w), .ovf(ovf_w), .sticky_ovf(sticky_w)
    );

    accum_bank #(.WIDTH(16), .CHANNELS(3), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_ch(in_ch), .in_op(in_op), .D(D), .clr_sticky(clr_sticky),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_ch(out_ch_s),
        .Q(q_s), .ovf(ovf_s), .sticky_ovf(sticky_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ch, input logic [2:0] op, input logic [15:0] d);
        in_valid = 1'b1;
        in_ch    = ch;
        in_op    = op;
        D        = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_op = '0; D = '0;
        clr_sticky = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid_w, 0);
        chk("rst_q", q_w, 0);
        chk("rst_sticky", sticky_w, 0);
        #10 rst_n = 1'b1;
        tick();

        drive(2'd0, 3'b001, 16'h1234); tick();
        chk("load0_valid", out_valid_w, 1);
        chk("load0_q", q_w, 16'h1234);
        chk("load0_ovf", ovf_w, 0);
        chk("load0_ch", out_ch_w, 0);
        drive(2'd0, 3'b010, 16'h0001); tick();
        chk("add0_q", q_w, 16'h1235);
        chk("add0_q_s", q_s, 16'h1235);
        chk("add0_ovf", ovf_w, 0);

        drive(2'd1, 3'b001, 16'h7FFF); tick();
        chk("load1_q", q_w, 16'h7FFF);
        drive(2'd1, 3'b010, 16'h0001); tick();
        chk("addovf_q_w", q_w, 16'h8000);
        chk("addovf_ovf_w", ovf_w, 1);
        chk("addovf_sticky_w", sticky_w, 4'b0010);
        chk("addovf_q_s", q_s, 16'h7FFF);
        chk("addovf_ovf_s", ovf_s, 1);
        chk("addovf_sticky_s", sticky_s, 3'b010);

        drive(2'd1, 3'b001, 16'h8000); tick();
        chk("loadmin_q_s", q_s, 16'h8000);
        drive(2'd1, 3'b011, 16'h0001); tick();
        chk("subovf_q_w", q_w, 16'h7FFF);
        chk("subovf_ovf_w", ovf_w, 1);
        chk("subovf_q_s", q_s, 16'h8000);
        chk("subovf_ovf_s", ovf_s, 1);

        drive(2'd2, 3'b001, 16'h0010); tick();
        chk("iso_load2", q_w, 16'h0010);
        drive(2'd3, 3'b001, 16'h0100); tick();
        chk("iso_load3", q_w, 16'h0100);
        chk("oor_q_s", q_s, 16'h0000);
        chk("oor_ch_s", out_ch_s, 2'd3);
        chk("oor_ovf_s", ovf_s, 0);
        drive(2'd2, 3'b010, 16'h0005); tick();
        chk("iso_add2", q_w, 16'h0015);
        chk("iso_add2_s", q_s, 16'h0015);
        drive(2'd3, 3'b000, 16'h0000); tick();
        chk("iso_read3", q_w, 16'h0100);
        chk("iso_read3_ch", out_ch_w, 2'd3);

        out_ready = 1'b0;
        drive(2'd2, 3'b010, 16'h0001);
        #1;
        chk("bp_in_ready", in_ready_w, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_q", q_w, 16'h0100);
            chk("bp_hold_ch", out_ch_w, 2'd3);
            chk("bp_hold_valid", out_valid_w, 1);
            chk("bp_hold_ready", in_ready_w, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready_w, 1);
        tick();
        chk("bp_result_q", q_w, 16'h0016);
        chk("bp_result_ch", out_ch_w, 2'd2);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid_w, 0);

        drive(2'd0, 3'b010, 16'h7FFF); tick();
        chk("ovf0_q_w", q_w, 16'h9234);
        chk("ovf0_sticky_w", sticky_w, 4'b0011);
        chk("ovf0_q_s", q_s, 16'h7FFF);
        chk("ovf0_sticky_s", sticky_s, 3'b011);

        drive(2'd1, 3'b010, 16'h0001);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clrset_q_w", q_w, 16'h8000);
        chk("clrset_sticky_w", sticky_w, 4'b0010);
        chk("clrset_q_s", q_s, 16'h8001);
        chk("clrset_sticky_s", sticky_s, 3'b000);

        drive(2'd1, 3'b100, 16'h5555); tick();
        chk("clear1_q", q_w, 16'h0000);
        chk("clear1_sticky", sticky_w, 4'b0000);

        drive(2'd2, 3'b000, 16'h0000); tick();
        chk("read2_after_stall", q_w, 16'h0016);
        drive(2'd2, 3'b101, 16'h1111); tick();
        chk("reserved_q", q_w, 16'h0016);
        chk("reserved_ovf", ovf_w, 0);

        drive(2'd3, 3'b001, 16'h7FFF); tick();
        drive(2'd3, 3'b010, 16'h7FFF); tick();
        chk("ovf3_q", q_w, 16'hFFFE);
        chk("ovf3_sticky", sticky_w, 4'b1000);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid_w, 0);
        chk("midrst_q", q_w, 16'h0000);
        chk("midrst_sticky", sticky_w, 4'b0000);
        #2 rst_n = 1'b1;
        tick();
        drive(2'd3, 3'b000, 16'h0000); tick();
        chk("postrst_read3", q_w, 16'h0000);
        chk("postrst_valid", out_valid_w, 1);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_bank.md
Name: accum_bank

Overview:
Parametrised successor to the datapath accumulator register. It holds CHANNELS independent signed accumulators of WIDTH bits each. Each accepted operation (load, add, sub, clear, read) targets one channel, and the result is returned through a single registered output stage with valid/ready flow control. Sits between the ALU operand path and the result bus; replaces the plain 16-bit output register.

Parameters:
WIDTH, 16, accumulator and data width in bits (>=2)
CHANNELS, 4, number of independent accumulators (>=1)
SATURATE, 0, 0 = two's-complement wrap on overflow; 1 = clamp to signed max/min

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation this cycle
in_ch  input  CH_W  target channel; CH_W = max(1, clog2(CHANNELS))
in_op  input  3  opcode
D  input  WIDTH  operand (signed)
clr_sticky  input  1  clears all sticky overflow bits
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_ch  output  CH_W  channel of presented result
Q  output  WIDTH  new value of the channel after the operation
ovf  output  1  this result overflowed (before saturation)
sticky_ovf  output  CHANNELS  per-channel sticky overflow

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately): all channel registers, Q, out_ch, ovf and sticky_ovf go to 0; out_valid goes to 0. Reset mid-operation discards any in-flight or pending result.
- Opcodes: 000 READ (no change), 001 LOAD (acc=D), 010 ADD (acc=acc+D), 011 SUB (acc=acc-D), 100 CLEAR (acc=0, sticky for that channel=0). Opcodes 101-111 are reserved and behave as READ.
- Accept condition: in_valid & in_ready. in_ready = !out_valid | out_ready (single output stage, full throughput).
- Latency: an op accepted in cycle N updates the channel register at the edge ending cycle N. Q/out_ch/ovf/out_valid present the result from cycle N+1.
- Back-to-back ops on the same channel see the updated value; there is no hazard and no bubble.
- Output hold: while out_valid & !out_ready, Q, out_ch and ovf stay stable and no new op is accepted. out_valid drops after a handshake with no new accept.
- Arithmetic: signed WIDTH-bit operations.
  - ADD overflow: operands share a sign and the result sign differs.
  - SUB overflow: operands differ in sign and the result sign differs from acc.
  - SATURATE=0: the wrapped result is stored.
  - SATURATE=1: the result is clamped to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - In both modes ovf=1 for that result. LOAD, CLEAR and READ give ovf=0.
- Sticky: sticky_ovf[ch] is set on an accepted overflowing op. It is cleared by CLEAR on ch or by clr_sticky (all channels). When a set and a clear coincide in the same cycle, the set wins.
- in_ch >= CHANNELS (non-power-of-2 CHANNELS): op is accepted, no state change, Q=0, ovf=0, out_ch=in_ch.

Decomposition:
- Package accum_pkg holds:
  - opcode localparams (OP_READ, OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR);
  - the CH_W derivation function;
  - signed max/min constant functions of WIDTH.
- One combinational sub-module, accum_addsub_sat (a, b, sub, sat → result, ovf), parametrised by WIDTH. The top holds the channel register array, sticky bits and output stage.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, Q and sticky_ovf are 0 within the same cycle, with no clock edge needed.
- LOAD ch0 0x1234, then ADD ch0 0x0001 on consecutive cycles with out_ready=1 -> Q=0x1234 then 0x1235 on consecutive cycles, ovf=0, out_ch=0.
- SATURATE=0: LOAD ch1 0x7FFF, ADD 0x0001 -> Q=0x8000, ovf=1, sticky_ovf[1]=1. SATURATE=1: same -> Q=0x7FFF; then LOAD 0x8000, SUB 0x0001 -> Q=0x8000, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, Q stable, channel unchanged. Release -> the pending op is accepted and its result appears the next cycle.
- Channel isolation: interleave LOAD ch2 0x0010 / LOAD ch3 0x0100 / ADD ch2 0x0005 / READ ch3 -> Q=0x0010, 0x0100, 0x0015, 0x0100.
- clr_sticky asserted in the same cycle as an overflowing ADD on ch1 -> sticky_ovf[1]=1 and all other bits 0. CLEAR ch1 -> Q=0, sticky_ovf[1]=0.
